// File: rtl/add_round_key_stream.sv
// AES AddRoundKey stage between streaming FIFOs: XORs each state block with a round key
// that is reused for a programmable number of blocks, with a one-entry output register.
module add_round_key_stream #(
    parameter int DATA_W    = 128,
    parameter int CNT_W     = 8,
    parameter int BLK_CNT_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    in_state,
    output logic                 in_state_rd,
    input  logic                 in_state_empty,
    input  logic [DATA_W-1:0]    round_key,
    output logic                 round_key_rd,
    input  logic                 round_key_empty,
    input  logic [CNT_W-1:0]     blocks_per_key,
    output logic [DATA_W-1:0]    out_state,
    output logic                 out_state_wr,
    input  logic                 out_state_full,
    output logic [BLK_CNT_W-1:0] block_count
);

    // state    | meaning
    // NO_KEY   | no key held; a block needs a key pop (bypass or load-only)
    // KEY_HELD | key_q valid for uses_left more blocks
    typedef enum logic {NO_KEY, KEY_HELD} state_t;

    state_t               state, state_nx;
    logic [DATA_W-1:0]    key_q;
    logic [DATA_W-1:0]    out_q, out_nx;
    logic [CNT_W-1:0]     uses_left, uses_nx, n_eff;
    logic                 out_vld, out_load, key_load, out_fire, out_free;
    logic                 st_rd, key_rd;
    logic [BLK_CNT_W-1:0] blk_cnt_q;

    assign n_eff        = (blocks_per_key == '0) ? CNT_W'(1) : blocks_per_key;
    assign out_fire     = out_vld && !out_state_full && !reset;
    assign out_free     = !out_vld || out_fire;
    assign out_state_wr = out_fire;
    assign out_state    = out_q;
    assign block_count  = blk_cnt_q;
    assign in_state_rd  = st_rd;
    assign round_key_rd = key_rd;

    always_comb begin
        state_nx = state;
        uses_nx  = uses_left;
        out_nx   = '0;
        out_load = 1'b0;
        key_load = 1'b0;
        st_rd    = 1'b0;
        key_rd   = 1'b0;
        if (!reset) begin
            case (state)
                NO_KEY: begin
                    if (!round_key_empty && !in_state_empty && out_free) begin
                        key_rd   = 1'b1;
                        st_rd    = 1'b1;
                        out_load = 1'b1;
                        out_nx   = in_state ^ round_key;
                        if (n_eff != CNT_W'(1)) begin
                            key_load = 1'b1;
                            uses_nx  = n_eff - CNT_W'(1);
                            state_nx = KEY_HELD;
                        end
                    end else if (!round_key_empty) begin
                        // no block can go this cycle, so park the key for later
                        key_rd   = 1'b1;
                        key_load = 1'b1;
                        uses_nx  = n_eff;
                        state_nx = KEY_HELD;
                    end
                end
                KEY_HELD: begin
                    if (!in_state_empty && out_free) begin
                        st_rd    = 1'b1;
                        out_load = 1'b1;
                        out_nx   = in_state ^ key_q;
                        uses_nx  = uses_left - CNT_W'(1);
                        if (uses_left == CNT_W'(1)) state_nx = NO_KEY;
                    end
                end
                default: state_nx = NO_KEY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= NO_KEY;
            key_q     <= '0;
            uses_left <= '0;
            out_vld   <= 1'b0;
            out_q     <= '0;
            blk_cnt_q <= '0;
        end else begin
            state     <= state_nx;
            uses_left <= uses_nx;
            if (key_load) key_q <= round_key;
            // a refill wins over a drain so back-to-back blocks never bubble
            if (out_load) begin
                out_q   <= out_nx;
                out_vld <= 1'b1;
            end else if (out_fire) begin
                out_vld <= 1'b0;
            end
            if (out_fire) blk_cnt_q <= blk_cnt_q + BLK_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_add_round_key_stream.sv
// Bench for add_round_key_stream: queue-modelled FIFOs, expected results pushed at issue
// time and popped by a monitor whenever the DUT writes.
module tb_add_round_key_stream;
    localparam int DW = 128;
    localparam int CW = 8;
    localparam int BW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_state = '0;
    logic [DW-1:0] round_key = '0;
    logic          in_state_empty = 1'b1;
    logic          round_key_empty = 1'b1;
    logic          out_state_full = 1'b0;
    logic [CW-1:0] blocks_per_key = 8'd1;
    wire           in_state_rd, round_key_rd, out_state_wr;
    wire  [DW-1:0] out_state;
    wire  [BW-1:0] block_count;
    wire           s_in_rd, s_key_rd, s_wr;
    wire  [DW-1:0] s_out;
    wire  [3:0]    s_count;

    add_round_key_stream #(.DATA_W(DW), .CNT_W(CW), .BLK_CNT_W(BW)) dut (
        .clock(clock), .reset(reset),
        .in_state(in_state), .in_state_rd(in_state_rd), .in_state_empty(in_state_empty),
        .round_key(round_key), .round_key_rd(round_key_rd), .round_key_empty(round_key_empty),
        .blocks_per_key(blocks_per_key),
        .out_state(out_state), .out_state_wr(out_state_wr), .out_state_full(out_state_full),
        .block_count(block_count)
    );

    // narrow-counter twin sharing all inputs, so counter wrap is reachable quickly
    add_round_key_stream #(.DATA_W(DW), .CNT_W(CW), .BLK_CNT_W(4)) dut_small (
        .clock(clock), .reset(reset),
        .in_state(in_state), .in_state_rd(s_in_rd), .in_state_empty(in_state_empty),
        .round_key(round_key), .round_key_rd(s_key_rd), .round_key_empty(round_key_empty),
        .blocks_per_key(blocks_per_key),
        .out_state(s_out), .out_state_wr(s_wr), .out_state_full(out_state_full),
        .block_count(s_count)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] sq[$];
    logic [DW-1:0] kq[$];
    logic [DW-1:0] expq[$];
    int total = 0, bad = 0, cyc = 0;
    int st_pops = 0, key_pops = 0, both_rd = 0, key_pop_at = -1;
    int first_wr = -1, last_wr = -1, first_pop = -1;
    bit st_pend = 1'b0, k_pend = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model plus scoreboard monitor; inputs only change right after a falling edge
    always @(negedge clock) begin
        if (st_pend && sq.size() > 0) begin
            void'(sq.pop_front());
            st_pops++;
        end
        if (k_pend && kq.size() > 0) begin
            void'(kq.pop_front());
            key_pops++;
            key_pop_at = st_pops;
        end
        #1;
        in_state        = (sq.size() > 0) ? sq[0] : '0;
        in_state_empty  = (sq.size() == 0);
        round_key       = (kq.size() > 0) ? kq[0] : '0;
        round_key_empty = (kq.size() == 0);
        #1;
        check("pop_from_empty", {in_state_rd & in_state_empty, round_key_rd & round_key_empty}, '0);
        check("twin_strobes", {s_wr, s_in_rd, s_key_rd}, {out_state_wr, in_state_rd, round_key_rd});
        if (out_state_wr) begin
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %0h expected no write", out_state);
            end else begin
                logic [DW-1:0] e;
                e = expq.pop_front();
                check("out_state", out_state, e);
            end
        end
        if (in_state_rd && first_pop < 0) first_pop = cyc;
        if (in_state_rd && round_key_rd) both_rd++;
        st_pend = in_state_rd;
        k_pend  = round_key_rd;
    end

    task automatic push_blk(input logic [DW-1:0] s, input logic [DW-1:0] e);
        sq.push_back(s);
        expq.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || sq.size() != 0) && n < 200) begin
            @(negedge clock);
            #3;
            n++;
        end
        if (expq.size() != 0 || sq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expq.size() + sq.size());
        end
        @(negedge clock);
        @(negedge clock);
        #3;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_k, base_s, base_b;
        logic [DW-1:0] k0, k1, k2, k3;

        // reset state
        repeat (3) @(negedge clock);
        #3;
        check("rst_out_state", out_state, '0);
        check("rst_wr", out_state_wr, '0);
        check("rst_count", block_count, '0);
        @(negedge clock);
        reset = 1'b0;

        // bypass streaming, one key per block
        @(negedge clock);
        blocks_per_key = 8'd1;
        base_b = both_rd; first_wr = -1; first_pop = -1;
        kq.push_back(128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F);
        kq.push_back(128'h2);
        kq.push_back({128{1'b1}});
        kq.push_back(128'h0000_0000_0000_0000_0000_0000_CAFE_BABE);
        push_blk(128'h00112233_44556677_8899AABB_CCDDEEFF, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        push_blk(128'h1, 128'h3);
        push_blk({128{1'b1}}, 128'h0);
        push_blk(128'hDEADBEEF_0000_0000_0000_0000_0000_0000, 128'hDEADBEEF_0000_0000_0000_0000_CAFE_BABE);
        drain();
        check("bypass_dual_pops", 128'(both_rd - base_b), 128'd4);
        check("bypass_wr_span", 128'(last_wr - first_wr), 128'd3);
        check("bypass_latency", 128'(first_wr - first_pop), 128'd1);
        check("bypass_count", block_count, 128'd4);

        // key reuse across three blocks
        blocks_per_key = 8'd3;
        base_k = key_pops; base_s = st_pops;
        k0 = {16{8'h0F}};
        k1 = {16{8'hF0}};
        kq.push_back(k0);
        kq.push_back(k1);
        push_blk(128'h0, {16{8'h0F}});
        push_blk(128'h1, {{15{8'h0F}}, 8'h0E});
        push_blk(128'h2, {{15{8'h0F}}, 8'h0D});
        push_blk(128'h3, {{15{8'hF0}}, 8'hF3});
        drain();
        check("reuse_key_pops", 128'(key_pops - base_k), 128'd2);
        check("reuse_second_key_at_4th", 128'(key_pop_at - base_s), 128'd4);
        check("reuse_count", block_count, 128'd8);
        check("reuse_uses_left", dut.uses_left, 128'd2);

        // backpressure with K1 still held for two blocks
        @(negedge clock);
        out_state_full = 1'b1;
        push_blk({16{8'hAA}}, {16{8'h5A}});
        push_blk(128'h0, {16{8'hF0}});
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #3;
            check("bp_no_pop", in_state_rd, '0);
            check("bp_no_wr", out_state_wr, '0);
            check("bp_out_stable", out_state, {16{8'h5A}});
            check("bp_uses_frozen", dut.uses_left, 128'd1);
        end
        @(negedge clock);
        out_state_full = 1'b0;
        #3;
        check("bp_release_wr_and_refill", {out_state_wr, in_state_rd}, 128'b11);
        drain();
        check("bp_count", block_count, 128'd10);

        // key arrives long before data
        blocks_per_key = 8'd3;
        base_k = key_pops;
        k2 = {4{32'h12345678}};
        kq.push_back(k2);
        repeat (10) @(negedge clock);
        #3;
        check("early_key_single_pop", 128'(key_pops - base_k), 128'd1);
        check("early_key_uses", dut.uses_left, 128'd3);
        @(negedge clock);
        k3 = {16{8'h3C}};
        kq.push_back(k3);
        blocks_per_key = 8'd1;
        out_state_full = 1'b1;
        sq.push_back({4{32'h11111111}});
        repeat (2) @(negedge clock);
        #3;
        check("early_key_xor", out_state, {4{32'h03254769}});
        check("early_key_uses_after", dut.uses_left, 128'd2);
        check("early_key_no_second_pop", 128'(key_pops - base_k), 128'd1);

        // reset while holding a key and an undrained result
        @(negedge clock);
        reset = 1'b1;
        #3;
        check("rst_strobes", {out_state_wr, in_state_rd, round_key_rd}, '0);
        @(negedge clock);
        reset = 1'b0;
        out_state_full = 1'b0;
        #3;
        check("rst_mid_out_state", out_state, '0);
        check("rst_mid_wr", out_state_wr, '0);
        check("rst_mid_count", block_count, '0);
        @(negedge clock);
        push_blk({16{8'hC3}}, {128{1'b1}});
        drain();
        check("post_rst_fresh_key", 128'(key_pops - base_k), 128'd2);
        check("post_rst_count", block_count, 128'd1);

        // blocks_per_key=0 acts as 1; narrow counter wraps at 15 -> 0
        blocks_per_key = 8'd0;
        base_k = key_pops; base_b = both_rd;
        for (int i = 0; i < 14; i++) begin
            kq.push_back({96'h0, 32'(i)});
            push_blk({32'(i), 96'h0}, {32'(i), 64'h0, 32'(i)});
        end
        drain();
        check("zero_key_pops", 128'(key_pops - base_k), 128'd14);
        check("zero_dual_pops", 128'(both_rd - base_b), 128'd14);
        check("wrap_pre_small", s_count, 128'hF);
        check("wrap_pre_count", block_count, 128'd15);
        kq.push_back(128'h5);
        push_blk(128'h50, 128'h55);
        drain();
        check("wrap_small", s_count, 128'h0);
        check("wrap_count", block_count, 128'd16);
        check("wrap_twin_out", s_out, 128'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
